// File: rtl/out_port_pkg.sv
// Shared constants and types for the buffered OUT port.
package out_port_pkg;

  localparam int unsigned OUT_WIDTH = 16;
  localparam int unsigned OUT_DEPTH = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fill_state_e;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/out_port_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module out_port_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// First-word-fall-through output FIFO behind the CPU OUT instruction.
// Define OUT_PORT_DROP_CNT_EN to build the saturating rejected-write counter.
module out_port_fifo
  import out_port_pkg::*;
#(
  parameter int unsigned WIDTH = OUT_WIDTH,
  parameter int unsigned DEPTH = OUT_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         wr_valid,
  input  logic [WIDTH-1:0]             wr_data,
  output logic                         wr_ready,
  output logic                         rd_valid,
  output logic [WIDTH-1:0]             rd_data,
  input  logic                         rd_ready,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic [WIDTH-1:0]             last_value,
  output logic [7:0]                   drop_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_fire;
  logic          rd_fire;
  fill_state_e   fill_state;

  // Flags depend only on the count register, so rd_ready never reaches wr_ready.
  assign wr_ready = (count != CW'(DEPTH));
  assign rd_valid = (count != CW'(0));
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;

  out_port_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clock (clock),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_value <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr     <= wr_ptr + PW'(1);
        last_value <= wr_data;
      end
      if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
      if (wr_fire && !rd_fire)      count <= count + CW'(1);
      else if (rd_fire && !wr_fire) count <= count - CW'(1);
    end
  end

`ifdef OUT_PORT_DROP_CNT_EN
  // Every cycle a write is offered while full counts once; saturates at 255.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (wr_valid && !wr_ready && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`else
  assign drop_count = '0;
`endif

  always_comb begin
    fill_state = PARTIAL;
    if (count == CW'(0))          fill_state = EMPTY;
    else if (count == CW'(DEPTH)) fill_state = FULL;
  end

  a_full_blocks_write: assert property (@(posedge clock) disable iff (!reset_n)
    (fill_state == FULL) |-> !wr_ready);
  a_empty_blocks_read: assert property (@(posedge clock) disable iff (!reset_n)
    (fill_state == EMPTY) |-> !rd_valid);

endmodule

// File: tb/tb_out_port_fifo.sv
// Scoreboard bench for out_port_fifo: reset, FWFT order across wrap, full/simultaneous, drops, async reset.
module tb_out_port_fifo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;

  logic             clock;
  logic             reset_n;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ready;
  logic [3:0]       count;
  logic [WIDTH-1:0] last_value;
  logic [7:0]       drop_count;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] sb[$];
  int               model_count = 0;
  logic [WIDTH-1:0] model_last  = '0;
  int               model_drop  = 0;

  out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .count      (count),
    .last_value (last_value),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare all observable state with the model (called mid-cycle, inputs settled).
  task automatic check_state();
    check("wr_ready", 32'(wr_ready), 32'(model_count != DEPTH));
    check("rd_valid", 32'(rd_valid), 32'(model_count != 0));
    check("count", 32'(count), 32'(model_count));
    check("last_value", 32'(last_value), 32'(model_last));
    check("drop_count", 32'(drop_count), 32'(model_drop));
    if (model_count != 0 && sb.size() != 0) check("rd_data", 32'(rd_data), 32'(sb[0]));
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic cycle(input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
    bit wacc;
    bit racc;
    logic [WIDTH-1:0] exp_head;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    wacc = wv && (model_count != DEPTH);
    racc = rr && (model_count != 0);
    @(negedge clock);
    check_state();
    if (racc) begin
      exp_head = sb.pop_front();
      check("read_word", 32'(rd_data), 32'(exp_head));
    end
    if (wacc) begin
      sb.push_back(wd);
      model_last = wd;
    end
`ifdef OUT_PORT_DROP_CNT_EN
    if (wv && model_count == DEPTH && model_drop != 255) model_drop++;
`endif
    if (wacc && !racc) model_count++;
    else if (racc && !wacc) model_count--;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    model_count = 0;
    model_last  = '0;
    model_drop  = 0;
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 16'hDEAD;
    rd_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_last_value", 32'(last_value), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    wr_valid = 1'b0;
    reset_n  = 1'b1;
    cycle(1'b0, '0, 1'b0);

    // Single OUT
    cycle(1'b1, 16'h0004, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("single_data", 32'(rd_data), 32'h0004);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Fill and wrap
    for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    repeat (3) cycle(1'b0, '0, 1'b1);
    for (int i = 9; i <= 11; i++) cycle(1'b1, 16'(i), 1'b0);
    repeat (8) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Simultaneous read and write while full
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'(16'h10 + i), 1'b0);
    cycle(1'b1, 16'h00AA, 1'b1);
    check("simul_count", 32'(count), 32'd7);
    cycle(1'b1, 16'h00AA, 1'b0);
    check("refill_count", 32'(count), 32'd8);

    // Rejected writes while full
    repeat (300) cycle(1'b1, 16'hBEEF, 1'b0);
`ifdef OUT_PORT_DROP_CNT_EN
    check("drop_saturated", 32'(drop_count), 32'd255);
`else
    check("drop_tied_off", 32'(drop_count), 32'd0);
`endif
    repeat (8) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Async reset mid-stream
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h50 + i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_rd_valid", 32'(rd_valid), 32'd0);
    check("async_wr_ready", 32'(wr_ready), 32'd1);
    check("async_last_value", 32'(last_value), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cycle(1'b1, 16'h1234, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("post_reset_data", 32'(rd_data), 32'h1234);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
